// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) / key-schedule helpers for the iterative decrypt core.
// Byte 0 of a 128-bit block is bits [127:120]; the state is column-major (byte r+4c).
package aes_pkg;

    typedef enum logic [2:0] {IDLE, KEYEXP, INIT, ROUND, FINAL} state_t;

    localparam int NR = 10;

    function automatic logic [7:0] rcon(input logic [3:0] i);
        logic [7:0] r;
        case (i)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // sub_rot is SubWord(RotWord(w3)) computed by the external S-box instances.
    function automatic logic [127:0] fwd_key(input logic [127:0] k, input logic [31:0] sub_rot,
                                             input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w0 = k[127:96] ^ sub_rot ^ {rc, 24'h000000};
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // sub_rot here must come from the recovered w3 (w3 ^ w2), not from the current w3.
    function automatic logic [127:0] inv_key(input logic [127:0] k, input logic [31:0] sub_rot,
                                             input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w3 = k[31:0] ^ k[63:32];
        w2 = k[63:32] ^ k[95:64];
        w1 = k[95:64] ^ k[127:96];
        w0 = k[127:96] ^ sub_rot ^ {rc, 24'h000000};
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Inverse AES S-box, 256-entry combinational lookup; 16 copies form InvSubBytes.
module aes_inv_sbox (
    input  logic [7:0] val,
    output logic [7:0] sub
);
    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    assign sub = INV_SBOX[val];
endmodule

// File: rtl/aes_sbox.sv
// Forward AES S-box, 256-entry combinational lookup; used by the key schedule.
module aes_sbox (
    input  logic [7:0] val,
    output logic [7:0] sub
);
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign sub = SBOX[val];
endmodule

// File: rtl/aes_decrypt_top.sv
// Iterative AES-128 decryption: expands the cipher key forward to rk10, then runs
// the inverse cipher one round per cycle while walking the key schedule backwards.
module aes_decrypt_top
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic         AES_clk,
    input  logic         AES_rst,
    input  logic         AES_en,
    input  logic [127:0] AES_data_in,
    input  logic [127:0] AES_key_in,
    output logic [127:0] AES_data_out,
    output logic         AES_data_out_valid,
    output logic         AES_busy
);
    if (NR != 10) begin : g_nr_check
        $error("aes_decrypt_top supports only NR = 10 (AES-128)");
    end

    state_t        state, next_state;
    logic [3:0]    cnt;
    logic [127:0]  data_reg;
    logic [127:0]  key_reg;
    logic [127:0]  isr;
    logic [127:0]  isb;
    logic [31:0]   sbox_in;
    logic [31:0]   sub_rot;
    logic [7:0]    rc;

    // InvShiftRows then InvSubBytes, shared by ROUND and FINAL
    assign isr = inv_shift_rows(data_reg);

    for (genvar i = 0; i < 16; i++) begin : g_inv_sbox
        aes_inv_sbox u_inv_sbox (.val(isr[8*i +: 8]), .sub(isb[8*i +: 8]));
    end

    // Forward expansion rotates the current w3; backward steps rotate the recovered w3.
    assign sbox_in = (state == KEYEXP) ? rot_word(key_reg[31:0])
                                       : rot_word(key_reg[31:0] ^ key_reg[63:32]);

    for (genvar j = 0; j < 4; j++) begin : g_key_sbox
        aes_sbox u_sbox (.val(sbox_in[8*j +: 8]), .sub(sub_rot[8*j +: 8]));
    end

    // cnt has run past NR by the time INIT is reached, so rcon[NR] is forced there.
    assign rc = (state == INIT) ? rcon(4'(NR)) : rcon(cnt);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (AES_en) next_state = KEYEXP;
            KEYEXP:  if (cnt == 4'(NR)) next_state = INIT;
            INIT:    next_state = ROUND;
            ROUND:   if (cnt == 4'd1) next_state = FINAL;
            FINAL:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge AES_clk or posedge AES_rst) begin
        if (AES_rst) begin
            state              <= IDLE;
            cnt                <= '0;
            data_reg           <= '0;
            key_reg            <= '0;
            AES_data_out       <= '0;
            AES_data_out_valid <= 1'b0;
            AES_busy           <= 1'b0;
        end else begin
            state              <= next_state;
            AES_busy           <= (next_state != IDLE);
            AES_data_out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (AES_en) begin
                        data_reg <= AES_data_in;
                        key_reg  <= AES_key_in;
                        cnt      <= 4'd1;
                    end
                end
                KEYEXP: begin
                    key_reg <= fwd_key(key_reg, sub_rot, rc);
                    cnt     <= cnt + 4'd1;
                end
                INIT: begin
                    data_reg <= data_reg ^ key_reg;
                    key_reg  <= inv_key(key_reg, sub_rot, rc);
                    cnt      <= 4'(NR - 1);
                end
                ROUND: begin
                    data_reg <= inv_mix_columns(isb ^ key_reg);
                    key_reg  <= inv_key(key_reg, sub_rot, rc);
                    cnt      <= cnt - 4'd1;
                end
                FINAL: begin
                    AES_data_out       <= isb ^ key_reg;
                    AES_data_out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_decrypt_top.sv
// Directed bench for aes_decrypt_top: FIPS-197 vectors, a round trip through a
// behavioural encryptor, busy-input noise, back-to-back starts and mid-op reset.
module tb_aes_decrypt_top;

    logic         clk;
    logic         rst;
    logic         en;
    logic [127:0] din;
    logic [127:0] kin;
    logic [127:0] dout;
    logic         valid;
    logic         busy;

    int total = 0;
    int bad   = 0;

    logic [7:0] sb [256];

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] RT_KEY = 128'haa2bdb40bff6a5e8caa9ba3ebc1e2acc;
    localparam logic [127:0] RT_PT  = 128'h00000030_00000000_00000000_00000000;

    aes_decrypt_top dut (
        .AES_clk            (clk),
        .AES_rst            (rst),
        .AES_en             (en),
        .AES_data_in        (din),
        .AES_key_in         (kin),
        .AES_data_out       (dout),
        .AES_data_out_valid (valid),
        .AES_busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] x, input int n);
        logic [7:0] y;
        y = x;
        for (int i = 0; i < n; i++) y = {y[6:0], y[7]};
        return y;
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] av, inv;
        for (int a = 0; a < 256; a++) begin
            av  = 8'(a);
            inv = 8'h00;
            if (av != 8'h00)
                for (int b = 1; b < 256; b++)
                    if (gm(av, 8'(b)) == 8'h01) inv = 8'(b);
            sb[a] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] enc(input logic [127:0] pt, input logic [127:0] key);
        logic [127:0] s, t, rk;
        logic [31:0]  w;
        logic [7:0]   rc, a0, a1, a2, a3;
        rk = key;
        s  = pt ^ rk;
        rc = 8'h01;
        t  = '0;
        for (int r = 1; r <= 10; r++) begin
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++)
                    t[127-8*(q+4*c) -: 8] = sb[s[127-8*(q+4*((c+q)%4)) -: 8]];
            if (r != 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[127-32*c -: 8];
                    a1 = t[119-32*c -: 8];
                    a2 = t[111-32*c -: 8];
                    a3 = t[103-32*c -: 8];
                    s[127-32*c -: 8] = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
                    s[119-32*c -: 8] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
                    s[111-32*c -: 8] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
                    s[103-32*c -: 8] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
                end
            end else begin
                s = t;
            end
            w = rk[31:0];
            w = {sb[w[23:16]] ^ rc, sb[w[15:8]], sb[w[7:0]], sb[w[31:24]]};
            rk[127:96] = rk[127:96] ^ w;
            rk[95:64]  = rk[95:64] ^ rk[127:96];
            rk[63:32]  = rk[63:32] ^ rk[95:64];
            rk[31:0]   = rk[31:0] ^ rk[63:32];
            rc = xt(rc);
            s  = s ^ rk;
        end
        return s;
    endfunction

    // One operation; cycle c is sampled 1 time unit after edge Ec (E0 = start edge).
    task automatic run_op(input logic [127:0] d, input logic [127:0] k, input bit noisy,
                          output logic [127:0] res, output int lat, output int busy_n,
                          output int pulses, output logic [127:0] key_init);
        @(negedge clk);
        en  = 1'b1;
        din = d;
        kin = k;
        @(posedge clk); #1;
        en       = 1'b0;
        lat      = -1;
        busy_n   = busy ? 1 : 0;
        pulses   = 0;
        res      = '0;
        key_init = '0;
        for (int c = 1; c <= 30; c++) begin
            if (noisy && c < 18) begin
                en  = ~en;
                din = {$urandom, $urandom, $urandom, $urandom};
                kin = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                en = 1'b0;
            end
            @(posedge clk); #1;
            if (busy) busy_n++;
            if (c == 10) key_init = dut.key_reg;
            if (valid) begin
                pulses++;
                if (lat < 0) begin
                    lat = c;
                    res = dout;
                end
            end
        end
        din = '0;
        kin = '0;
    endtask

    initial begin
        logic [127:0] res, kinit, ct, o0, o1;
        int lat, bn, pul, p, t0, t1;

        rst = 1'b1;
        en  = 1'b0;
        din = '0;
        kin = '0;
        build_sbox();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", dout, '0);
        chk("rst_valid", 128'(valid), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(C1_CT, C1_KEY, 1'b0, res, lat, bn, pul, kinit);
        chk("c1_out", res, C1_PT);
        chk("c1_latency", 128'(lat), 128'd21);
        chk("c1_busy_cycles", 128'(bn), 128'd21);
        chk("c1_pulses", 128'(pul), 128'd1);

        run_op(B_CT, B_KEY, 1'b0, res, lat, bn, pul, kinit);
        chk("appb_out", res, B_PT);
        chk("appb_rk10_at_init", kinit, B_RK10);
        chk("appb_latency", 128'(lat), 128'd21);

        ct = enc(RT_PT, RT_KEY);
        run_op(ct, RT_KEY, 1'b0, res, lat, bn, pul, kinit);
        chk("roundtrip_out", res, RT_PT);
        chk("roundtrip_pulses", 128'(pul), 128'd1);

        run_op(C1_CT, C1_KEY, 1'b1, res, lat, bn, pul, kinit);
        chk("noisy_out", res, C1_PT);
        chk("noisy_pulses", 128'(pul), 128'd1);
        chk("noisy_latency", 128'(lat), 128'd21);

        // Back-to-back: en held high, second vector captured when IDLE is re-entered.
        @(negedge clk);
        en  = 1'b1;
        din = C1_CT;
        kin = C1_KEY;
        @(posedge clk); #1;
        din = B_CT;
        kin = B_KEY;
        p = 0; t0 = -1; t1 = -1; o0 = '0; o1 = '0;
        for (int c = 1; c <= 50; c++) begin
            @(posedge clk); #1;
            if (valid) begin
                if (p == 0) begin t0 = c; o0 = dout; end
                if (p == 1) begin t1 = c; o1 = dout; end
                p++;
            end
            if (c == 22) en = 1'b0;
        end
        chk("b2b_pulses", 128'(p), 128'd2);
        chk("b2b_first_at", 128'(t0), 128'd21);
        chk("b2b_gap", 128'(t1 - t0), 128'd22);
        chk("b2b_out0", o0, C1_PT);
        chk("b2b_out1", o1, B_PT);

        // Reset during ROUND: outputs clear asynchronously and no pulse follows.
        @(negedge clk);
        en  = 1'b1;
        din = B_CT;
        kin = B_KEY;
        @(posedge clk); #1;
        en = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_out", dout, '0);
        chk("midrst_valid", 128'(valid), 128'd0);
        chk("midrst_busy", 128'(busy), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        pul = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (valid) pul++;
        end
        chk("midrst_no_pulse", 128'(pul), 128'd0);
        run_op(C1_CT, C1_KEY, 1'b0, res, lat, bn, pul, kinit);
        chk("after_rst_out", res, C1_PT);
        chk("after_rst_latency", 128'(lat), 128'd21);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_decrypt_top.md
Name: aes_decrypt_top

Overview:
- Iterative AES-128 decryption core; the inverse of the AES_top encryption core.
- Takes ciphertext plus the cipher key (round key 0, the same key given to AES_top).
- First expands the key forward to round key 10, then runs the inverse cipher while recomputing round keys backwards.
- Sits beside AES_top on the same clock with a mirrored en/data/key/valid interface. Used for round-trip checking and for the decrypt path.

Parameters:
- NR, 10, number of rounds; only 10 (AES-128) is supported, other values are a compile-time error.

Ports:
- AES_clk  input  1  system clock, rising edge.
- AES_rst  input  1  asynchronous, active-high reset.
- AES_en  input  1  start request; sampled only in IDLE.
- AES_data_in  input  128  ciphertext; bit 127 = byte 0 (FIPS-197 order).
- AES_key_in  input  128  cipher key (round key 0), same byte order.
- AES_data_out  output  128  plaintext; holds its value until the next result.
- AES_data_out_valid  output  1  one-cycle pulse when AES_data_out updates.
- AES_busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (async, any state): state=IDLE, cnt=0, data_reg=0, key_reg=0, AES_data_out=0, AES_data_out_valid=0, AES_busy=0.
- Edge numbering: E0 is the edge where AES_en=1 is sampled in IDLE; E1, E2, ... are the following edges.
- IDLE, AES_en=1 at E0:
  - data_reg<=AES_data_in, key_reg<=AES_key_in, cnt<=1, go to KEYEXP.
  - AES_en is level-sensitive: if it is still high when the core returns to IDLE, a new operation starts on that edge.
- KEYEXP (E1..E10):
  - key_reg<=fwd_key(key_reg, rcon[cnt]), using RotWord/SubWord/rcon XOR chain; cnt<=cnt+1.
  - At E10 key_reg=rk10 (the cnt=10 step); go to INIT.
- INIT (E11):
  - data_reg<=data_reg^rk10.
  - key_reg<=inv_key(rk10, rcon[10]) = rk9; cnt<=9; go to ROUND.
  - inv_key: w[i]^=w[i-1] for i=3..1, then w0^=SubWord(RotWord(w3_new))^rcon.
- ROUND (E12..E20, cnt 9..1):
  - data_reg<=InvMixColumns(InvSubBytes(InvShiftRows(data_reg))^key_reg).
  - key_reg<=inv_key(key_reg, rcon[cnt]); cnt<=cnt-1.
  - On cnt==1, go to FINAL; key_reg is now rk0.
- FINAL (E21):
  - AES_data_out<=InvSubBytes(InvShiftRows(data_reg))^key_reg.
  - AES_data_out_valid<=1 for exactly one cycle; go to IDLE.
- Latency: start sampled at E0, valid high after E21 (21 cycles); throughput is one block per 22 cycles when AES_en is held high.
- Input changes: AES_en, AES_data_in and AES_key_in are ignored while busy. Inputs are captured only at E0.
- Reset mid-operation: operation aborted, no valid pulse, AES_data_out cleared to 0.
- Encoding: all GF(2^8) arithmetic uses polynomial 0x11B. InvMixColumns coefficients are {0e,0b,0d,09}.
- No combinational path from inputs to outputs; all outputs are registered.

Decomposition:
- Shared package aes_pkg contains:
  - state enum IDLE/KEYEXP/INIT/ROUND/FINAL,
  - NR,
  - rcon table (index 1..10: 01,02,04,08,10,20,40,80,1b,36),
  - functions xtime, gmul, fwd_key, inv_key, inv_shift_rows, inv_mix_columns.
- Sub-module aes_inv_sbox (256-entry combinational LUT), instantiated 16 times for InvSubBytes.
- The key schedule reuses the existing forward S-box module (4 instances).

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, in 69c4e0d86a7b0430d8cdb78070b4c55a -> out 00112233445566778899aabbccddeeff, valid exactly 21 cycles after the start edge, AES_busy high for 21 cycles.
- FIPS-197 App.B: key 2b7e151628aed2a6abf7158809cf4f3c, in 3925841d02dc09fbdc118597196a0b32 -> out 3243f6a8885a308d313198a2e0370734; bench probe confirms key_reg=d014f9a8c9ee2589e13f0cc8b6630ca6 at INIT.
- Round trip: AES_top encrypts 00000030_00000000_00000000_00000000 under key aa2bdb40bff6a5e8caa9ba3ebc1e2acc; its output fed here -> out 00000030_00000000_00000000_00000000.
- Busy handling: during an operation toggle AES_en and change AES_data_in/AES_key_in every cycle -> result still the C.1 plaintext, single valid pulse.
- Back-to-back: hold AES_en=1 with C.1 then App.B vectors -> two valid pulses 22 cycles apart, correct plaintexts in order.
- Reset mid-op: assert AES_rst at cycle 12 of an operation -> outputs 0 immediately, no valid pulse; the next operation yields the correct result.
